// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Types and defaults shared by the mining-side blocks around the SHA core.
//   arb_state_t  : sha_core_arbiter FSM states {IDLE, START, WAIT, DONE}
//   DEF_NUM_REQ  : default number of controllers sharing one core
//   DEF_TIMEOUT  : default watchdog limit in WAIT cycles
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping past N-1 back to 0.
// Ports:
//   req    in  N  request vector
//   ptr    in  W  starting index for the search (must be < N)
//   found  out 1  at least one request asserted
//   idx    out W  binary index of the chosen request (== ptr when !found)
//   onehot out N  one-hot form of idx, all-zero when !found
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    localparam int IW = $clog2(2 * N);
    localparam logic [W:0] N_VAL = (W + 1)'(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;
    logic [W:0]     sum;

    // Rotating by ptr puts the highest-priority candidate at bit 0, so a
    // plain lowest-bit priority encoder gives the round-robin winner.
    assign req_dbl = {req, req};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW-1:0] pos;
            assign pos     = IW'(ptr) + IW'(gi);
            assign rot[gi] = req_dbl[pos];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = W'(i);
            end
        end
        // Undo the rotation: (ptr + off) mod N, with one extra bit of headroom.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
        idx = sum[W-1:0];
    end

    assign found = |req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot[gi] = found && (idx == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/sha_core_arbiter.sv
// ---------------------------------------------------------------------------
// sha_core_arbiter
// Shares one SHA-256 core between NUM_REQ mining controllers. The winner of a
// round-robin pick owns the core for one hash: the core gets a one-cycle
// start, the arbiter waits for complete, pulses done to the owner and
// releases the core. sel drives the core's message/nonce input mux.
//
// Optional feature macro: SHA_WATCHDOG_EN
//   defined   : WAIT is bounded to TIMEOUT cycles; on expiry error goes high
//               (sticky), the core is released without done.
//   undefined : WAIT holds until complete; error is tied low.
//
// Ports:
//   clk          in  1        rising-edge clock
//   n_rst        in  1        synchronous active-low reset
//   req          in  NUM_REQ  per-controller request (level, held until done)
//   sha_complete in  1        core finished (level or pulse, used in WAIT only)
//   sha_start    out 1        one-cycle start pulse to the core
//   grant        out NUM_REQ  one-hot owner, zero when idle
//   sel          out SEL_W    binary owner index for the core input mux
//   done         out NUM_REQ  one-hot one-cycle completion pulse to owner
//   busy         out 1        core allocated (state != IDLE)
//   error        out 1        watchdog expired (sticky until reset)
// ---------------------------------------------------------------------------
module sha_core_arbiter
    import miner_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SEL_W   = $clog2(NUM_REQ),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               sha_complete,
    output logic               sha_start,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               error
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_params
            $error("sha_core_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 1");
        end
    endgenerate

    arb_state_t         state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [SEL_W-1:0]   ptr_after;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

`ifdef SHA_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            err_reg, err_next;
`endif

    rr_pick #(
        .N (NUM_REQ),
        .W (SEL_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Next search starts just past the owner that is being released.
    assign ptr_after = (sel_reg == SEL_W'(NUM_REQ - 1)) ? '0 : sel_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
`ifdef SHA_WATCHDOG_EN
        wd_cnt_next = wd_cnt_reg;
        err_next    = err_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_onehot;
                    sel_next   = pick_idx;
                    state_next = START;
                end
            end
            START: begin
                // Complete seen during START belongs to no transaction of ours.
                state_next = WAIT;
`ifdef SHA_WATCHDOG_EN
                wd_cnt_next = '0;
`endif
            end
            WAIT: begin
                if (sha_complete) begin
                    state_next = DONE;
                end
`ifdef SHA_WATCHDOG_EN
                // Complete on the final allowed cycle still wins.
                else if (wd_cnt_reg == WD_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = ptr_after;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                ptr_next   = ptr_after;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
`ifdef SHA_WATCHDOG_EN
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
`ifdef SHA_WATCHDOG_EN
            wd_cnt_reg <= wd_cnt_next;
            err_reg    <= err_next;
`endif
        end
    end

    assign sha_start = (state_reg == START);
    assign busy      = (state_reg != IDLE);
    assign grant     = grant_reg;
    assign sel       = sel_reg;
    assign done      = (state_reg == DONE) ? grant_reg : '0;

`ifdef SHA_WATCHDOG_EN
    assign error = err_reg;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sha_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha_core_arbiter
// Directed stimulus for sha_core_arbiter (NUM_REQ=4, TIMEOUT=8). Expected
// starts and dones are queued by the stimulus; a negedge monitor pops and
// compares whenever the DUT pulses sha_start or done.
// ---------------------------------------------------------------------------
module tb_sha_core_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [N-1:0] req = '0;
    logic         sha_complete = 1'b0;
    logic         sha_start;
    logic [N-1:0] grant;
    logic [1:0]   sel;
    logic [N-1:0] done;
    logic         busy;
    logic         error;

    sha_core_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req          (req),
        .sha_complete (sha_complete),
        .sha_start    (sha_start),
        .grant        (grant),
        .sel          (sel),
        .done         (done),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int bad = 0;

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   s;
    } start_exp_t;

    typedef struct {
        logic [N-1:0] g;
        int           c;
    } done_exp_t;

    start_exp_t start_q[$];
    done_exp_t  done_q[$];
    start_exp_t mon_se;
    done_exp_t  mon_de;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every start/done the DUT shows must match the next queued entry.
    always @(negedge clk) begin
        if (sha_start) begin
            if (start_q.size() == 0) begin
                checks++;
                bad++;
                $display("FAIL unexpected_start: grant=%b with nothing expected", grant);
            end else begin
                mon_se = start_q.pop_front();
                check("start_grant", {28'd0, grant}, {28'd0, mon_se.g});
                check("start_sel", {30'd0, sel}, {30'd0, mon_se.s});
                $display("txn start grant=%b sel=%0d cycle=%0d", grant, sel, cyc);
            end
        end
        if (done != '0) begin
            if (done_q.size() == 0) begin
                checks++;
                bad++;
                $display("FAIL unexpected_done: done=%b with nothing expected", done);
            end else begin
                mon_de = done_q.pop_front();
                check("done_vec", {28'd0, done}, {28'd0, mon_de.g});
                check("done_cycle", cyc, mon_de.c);
                $display("txn done=%b cycle=%0d", done, cyc);
            end
        end
    end

    // Queue the expected start, then wait (bounded) for it. exp_n is the
    // number of negedges from the call to the START cycle, 0 = unchecked.
    task automatic wait_start(input logic [N-1:0] g, input logic [1:0] s, input int exp_n);
        int n;
        n = 0;
        start_q.push_back('{g, s});
        do begin
            @(negedge clk);
            n++;
        end while (!sha_start && n < 30);
        checks++;
        if (!sha_start) begin
            bad++;
            $display("FAIL start_timeout: no sha_start after %0d cycles, expected grant %b", n, g);
        end
        if (exp_n > 0) check("start_latency", n, exp_n);
    endtask

    // From START: complete on the lat-th WAIT cycle, done due one cycle later.
    task automatic finish_txn(input logic [N-1:0] g, input int lat);
        repeat (lat) @(negedge clk);
        sha_complete = 1'b1;
        done_q.push_back('{g, cyc + 1});
        @(negedge clk);
        sha_complete = 1'b0;
    endtask

    task automatic do_reset(input int n);
        n_rst = 1'b0;
        repeat (n) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, {28'd0, grant}, 32'd0);
        check({tag, "_sel"}, {30'd0, sel}, 32'd0);
        check({tag, "_done"}, {28'd0, done}, 32'd0);
        check({tag, "_start"}, {31'd0, sha_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    logic [N-1:0] order[5];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_rst = 1'b1;

        // Single requester, grant one cycle after req, done after complete
        req = 4'b0100;
        wait_start(4'b0100, 2'd2, 1);
        check("t1_busy_start", {31'd0, busy}, 32'd1);
        finish_txn(4'b0100, 5);
        req = '0;
        @(negedge clk);
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_grant", {28'd0, grant}, 32'd0);

        // All requesting from pointer 0: full rotation and wrap
        do_reset(2);
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(order[i], 2'(i % 4), (i == 0) ? 1 : 2);
            finish_txn(order[i], 2);
        end

        // Pointer now 1: 1001 serves bit 3 before bit 0
        req = 4'b1001;
        wait_start(4'b1000, 2'd3, 2);
        finish_txn(4'b1000, 1);
        wait_start(4'b0001, 2'd0, 2);
        finish_txn(4'b0001, 1);
        req = '0;

        // Owner drops req during WAIT, done still delivered
        @(negedge clk);
        req = 4'b0110;
        wait_start(4'b0010, 2'd1, 1);
        @(negedge clk);
        req = 4'b0100;
        finish_txn(4'b0010, 2);
        wait_start(4'b0100, 2'd2, 2);
        finish_txn(4'b0100, 1);
        req = '0;

        // Reset during WAIT aborts the transaction; later complete ignored
        @(negedge clk);
        req = 4'b0001;
        wait_start(4'b0001, 2'd0, 1);
        @(negedge clk);
        n_rst = 1'b0;
        req = '0;
        @(negedge clk);
        check_all_zero("abort");
        n_rst = 1'b1;
        sha_complete = 1'b1;
        @(negedge clk);
        sha_complete = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);

        // Complete during START is not counted
        req = 4'b0010;
        wait_start(4'b0010, 2'd1, 1);
        sha_complete = 1'b1;
        @(negedge clk);
        sha_complete = 1'b0;
        repeat (3) @(negedge clk);
        check("start_cpl_busy", {31'd0, busy}, 32'd1);
        finish_txn(4'b0010, 1);
        req = '0;

`ifdef SHA_WATCHDOG_EN
        // Watchdog: 8 WAIT cycles without complete
        @(negedge clk);
        req = 4'b0100;
        wait_start(4'b0100, 2'd2, 1);
        repeat (8) @(negedge clk);
        req = '0;
        check("wd_busy_last", {31'd0, busy}, 32'd1);
        check("wd_err_before", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("wd_error", {31'd0, error}, 32'd1);
        check("wd_busy", {31'd0, busy}, 32'd0);
        check("wd_grant", {28'd0, grant}, 32'd0);
        // Pointer advanced past 2 to 3, so 0101 wraps to bit 0
        req = 4'b0101;
        wait_start(4'b0001, 2'd0, 1);
        finish_txn(4'b0001, 1);
        req = '0;
        check("wd_error_sticky", {31'd0, error}, 32'd1);

        // Complete on the 8th WAIT cycle wins over the watchdog
        do_reset(2);
        check("wd_err_reset", {31'd0, error}, 32'd0);
        req = 4'b1000;
        wait_start(4'b1000, 2'd3, 1);
        finish_txn(4'b1000, 8);
        req = '0;
        check("wd_edge_err", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("wd_edge_err_idle", {31'd0, error}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("start_q_left", start_q.size(), 32'd0);
        check("done_q_left", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
